// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

   // Memory size codes; SZ_LOAD doubles as "read" on the memory side
   localparam logic [1:0] SZ_LOAD = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   // Wide enough for RD_LAT-1 with RD_LAT up to 7
   localparam int CNT_W = 3;

   // Captured transaction, held on the memory port for the ISSUE cycle
   typedef struct packed {
      logic        ce;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side bus of the data-memory port arbiter.
interface dmem_port_arbiter_if;

   // fetch requester
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   // load/store requester
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;

   // memory port
   logic        mem_ce;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        busy;

   // arbiter side
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      output mem_ce, mem_we, mem_size, mem_addr, mem_wdata, busy
   );

   // requester/memory side
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
      input  mem_ce, mem_we, mem_size, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; bit 0 = fetch, bit 1 = load/store.
module rr_arbiter2
   import dmem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   owner_t last_owner_q, last_owner_d;

   // A lone requester wins; on a tie the port not served last wins
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last_owner_q == OWN_LS) ? 2'b01 : 2'b10;
      end
   end

   // Remember who was served, only when a grant is actually taken
   always_comb begin
      last_owner_d = last_owner_q;
      if (advance && (gnt != 2'b00)) begin
         last_owner_d = gnt[1] ? OWN_LS : OWN_IF;
      end
   end

   // Starts as if LS went last, so the first tie goes to fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner_q <= OWN_LS;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the load/store
// unit: one transaction at a time, one issue cycle, fixed read latency.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned RD_LAT = 1   // issue cycle to mem_rdata valid, 1..7
) (
   input  logic               clk,
   input  logic               reset,
   dmem_port_arbiter_if.slave bus
);

   arb_state_t       state_q, state_d;
   owner_t           owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_req_t         mem_q, mem_d;

   logic       idle;
   logic       ls_store;
   logic       rsp_fire;
   logic       if_rv, ls_rv;
   logic [1:0] arb_req, arb_gnt;

   // Grants only come out of IDLE; reset suppresses them in the same cycle
   assign idle    = (state_q == IDLE) && !reset;
   assign arb_req = idle ? {bus.ls_req, bus.if_req} : 2'b00;

   // A store with size 00 is not a store; it goes out as a load
   assign ls_store = bus.ls_we && (bus.ls_size != SZ_LOAD);

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (idle),
      .gnt     (arb_gnt)
   );

   // Capture the winner in IDLE, drive the port for one ISSUE cycle,
   // then count the read latency down in WAIT
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      mem_d   = '0;
      case (state_q)
         IDLE: begin
            if (arb_gnt[1]) begin
               state_d     = ISSUE;
               owner_d     = OWN_LS;
               mem_d.ce    = 1'b1;
               mem_d.we    = ls_store;
               mem_d.size  = ls_store ? bus.ls_size : SZ_LOAD;
               mem_d.addr  = bus.ls_addr;
               mem_d.wdata = ls_store ? bus.ls_wdata : '0;
            end else if (arb_gnt[0]) begin
               state_d     = ISSUE;
               owner_d     = OWN_IF;
               mem_d.ce    = 1'b1;
               mem_d.we    = 1'b0;
               mem_d.size  = SZ_WORD;
               mem_d.addr  = bus.if_addr;
               mem_d.wdata = '0;
            end
         end
         ISSUE: begin
            if (mem_q.we) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               cnt_d   = CNT_W'(RD_LAT - 1);
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured transaction; mem_q is nonzero only during ISSUE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         cnt_q   <= '0;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
      end
   end

   // Read data is a pass-through in the last WAIT cycle, dropped under reset
   assign rsp_fire = (state_q == WAIT) && (cnt_q == '0) && !reset;
   assign if_rv    = rsp_fire && (owner_q == OWN_IF);
   assign ls_rv    = rsp_fire && (owner_q == OWN_LS);

   assign bus.if_gnt    = arb_gnt[0];
   assign bus.ls_gnt    = arb_gnt[1];
   assign bus.if_rvalid = if_rv;
   assign bus.ls_rvalid = ls_rv;
   assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
   assign bus.ls_rdata  = ls_rv ? bus.mem_rdata : '0;

   assign bus.mem_ce    = mem_q.ce;
   assign bus.mem_we    = mem_q.we;
   assign bus.mem_size  = mem_q.size;
   assign bus.mem_addr  = mem_q.addr;
   assign bus.mem_wdata = mem_q.wdata;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (RD_LAT 1, 3, 4) share one
// stimulus; a timeline model predicts every output of each instance.
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   localparam int NK = 3;
   localparam logic [11:0] LATS = {4'd4, 4'd3, 4'd1};

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        ls_req, ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, mem_rdata;
   bit          rdata_fixed;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0]  o_gnt  [NK];   // {ls, if}
   logic [65:0] o_rsp  [NK];   // {ls_rvalid, if_rvalid, if_rdata, ls_rdata}
   logic [35:0] o_mem  [NK];   // {ce, we, size, addr}
   logic [31:0] o_wd   [NK];
   logic        o_busy [NK];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NK; k++) begin : g_dut
      dmem_port_arbiter_if bus ();
      assign bus.if_req    = if_req;
      assign bus.if_addr   = if_addr;
      assign bus.ls_req    = ls_req;
      assign bus.ls_we     = ls_we;
      assign bus.ls_size   = ls_size;
      assign bus.ls_addr   = ls_addr;
      assign bus.ls_wdata  = ls_wdata;
      assign bus.mem_rdata = mem_rdata;

      dmem_port_arbiter #(.RD_LAT(LATS[k*4 +: 4])) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      assign o_gnt[k]  = {bus.ls_gnt, bus.if_gnt};
      assign o_rsp[k]  = {bus.ls_rvalid, bus.if_rvalid, bus.if_rdata, bus.ls_rdata};
      assign o_mem[k]  = {bus.mem_ce, bus.mem_we, bus.mem_size, bus.mem_addr};
      assign o_wd[k]   = bus.mem_wdata;
      assign o_busy[k] = bus.busy;
   end

   // memory returns a fresh random word every cycle unless pinned
   always @(posedge clk) begin
      #1;
      if (!rdata_fixed) mem_rdata = $urandom;
   end

   // ---------------- reference model ----------------
   // Each instance is described by the cycle numbers at which its current
   // transaction issues, returns data and frees the port.
   int          cyc = 0;
   int          m_free [NK];
   int          m_issue[NK];
   int          m_resp [NK];
   bit          m_ls   [NK];
   bit          m_wr   [NK];
   bit          m_last [NK];   // 1: LS was served last
   logic [1:0]  m_sz   [NK];
   logic [31:0] m_ad   [NK];
   logic [31:0] m_wd   [NK];

   function automatic int lat(input int k);
      return int'(LATS[k*4 +: 4]);
   endfunction

   function automatic logic [1:0] m_pick(input int k);
      if (reset || cyc < m_free[k]) return 2'b00;
      if (if_req && ls_req) return m_last[k] ? 2'b01 : 2'b10;
      return {ls_req, if_req};
   endfunction

   function automatic logic [35:0] m_mem(input int k);
      if (cyc != m_issue[k]) return 36'h0;
      return {1'b1, m_wr[k], m_sz[k], m_ad[k]};
   endfunction

   function automatic logic [65:0] m_rsp(input int k);
      logic ev;
      ev = !reset && (cyc == m_resp[k]);
      return {ev && m_ls[k], ev && !m_ls[k],
              (ev && !m_ls[k]) ? mem_rdata : 32'h0,
              (ev &&  m_ls[k]) ? mem_rdata : 32'h0};
   endfunction

   always @(posedge clk) begin : model_upd
      logic [1:0] g;
      for (int k = 0; k < NK; k++) begin
         g = m_pick(k);
         if (reset) begin
            m_last[k]  = 1'b1;
            m_free[k]  = cyc + 1;
            m_issue[k] = -1;
            m_resp[k]  = -1;
         end else if (g != 2'b00) begin
            m_ls[k]    = g[1];
            m_wr[k]    = g[1] && ls_we && (ls_size != SZ_LOAD);
            m_sz[k]    = !g[1] ? SZ_WORD : (m_wr[k] ? ls_size : SZ_LOAD);
            m_ad[k]    = g[1] ? ls_addr : if_addr;
            m_wd[k]    = ls_wdata;
            m_issue[k] = cyc + 1;
            m_resp[k]  = m_wr[k] ? -1 : cyc + 1 + lat(k);
            m_free[k]  = m_wr[k] ? cyc + 2 : cyc + 2 + lat(k);
            m_last[k]  = g[1];
         end
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req   = 1'b0;
      if_addr  = 32'h0;
      ls_req   = 1'b0;
      ls_we    = 1'b0;
      ls_size  = SZ_LOAD;
      ls_addr  = 32'h0;
      ls_wdata = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if ({o_gnt[k], o_rsp[k], o_mem[k], o_wd[k], o_busy[k]} !== 137'h0) begin
            n_err++;
            $display("FAIL reset_outputs k=%0d got gnt=%b rsp=%h mem=%h wd=%h busy=%b want all 0",
                     k, o_gnt[k], o_rsp[k], o_mem[k], o_wd[k], o_busy[k]);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      if_req  = 1'b1;
      if_addr = 32'h100;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (o_gnt[k] !== 2'b01) begin
            n_err++;
            $display("FAIL midrd_gnt k=%0d got %b want 01", k, o_gnt[k]);
         end
      end
      tick();
      if_req = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      for (int k = 1; k < NK; k++) begin
         n_cmp++;
         if (o_rsp[k][65:64] !== 2'b00) begin
            n_err++;
            $display("FAIL midrd_rv_in_reset k=%0d got %b want 00", k, o_rsp[k][65:64]);
         end
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            n_cmp++;
            if ({o_gnt[k], o_rsp[k], o_mem[k], o_wd[k], o_busy[k]} !== 137'h0) begin
               n_err++;
               $display("FAIL midrd_after_reset k=%0d c=%0d got rsp=%h mem=%h busy=%b want all 0",
                        k, c, o_rsp[k], o_mem[k], o_busy[k]);
            end
         end
         tick();
      end
   endtask

   task automatic test_if_read();
      logic        ev;
      logic [65:0] er;
      do_reset();
      rdata_fixed = 1'b1;
      mem_rdata   = 32'hDEAD_BEEF;
      if_req      = 1'b1;
      if_addr     = 32'h40;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (o_gnt[k] !== 2'b01) begin
            n_err++;
            $display("FAIL ifrd_gnt k=%0d got %b want 01", k, o_gnt[k]);
         end
      end
      tick();
      if_req  = 1'b0;
      if_addr = 32'hFFFF_FFFC;   // change after grant must not matter
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (o_mem[k] !== {1'b1, 1'b0, 2'b11, 32'h40}) begin
            n_err++;
            $display("FAIL ifrd_issue k=%0d got %h want %h", k, o_mem[k], {1'b1, 1'b0, 2'b11, 32'h40});
         end
      end
      for (int c = 2; c <= 6; c++) begin
         tick();
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            ev = (c == 1 + lat(k));
            er = {1'b0, ev, ev ? 32'hDEAD_BEEF : 32'h0, 32'h0};
            n_cmp++;
            if (o_rsp[k] !== er) begin
               n_err++;
               $display("FAIL ifrd_resp k=%0d c=%0d got %h want %h", k, c, o_rsp[k], er);
            end
            n_cmp++;
            if (o_busy[k] !== (c <= 1 + lat(k))) begin
               n_err++;
               $display("FAIL ifrd_busy k=%0d c=%0d got %b want %b", k, c, o_busy[k], c <= 1 + lat(k));
            end
         end
      end
      tick();
      rdata_fixed = 1'b0;
   endtask

   task automatic test_ls_store();
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_size  = SZ_BYTE;
      ls_addr  = 32'h200;
      ls_wdata = 32'h0000_00AB;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (o_gnt[k] !== 2'b10) begin
            n_err++;
            $display("FAIL st_gnt k=%0d got %b want 10", k, o_gnt[k]);
         end
      end
      tick();
      ls_we   = 1'b0;            // a load now waits behind the store
      ls_size = SZ_LOAD;
      ls_addr = 32'h204;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if ({o_mem[k], o_wd[k], o_gnt[k], o_rsp[k][65:64]} !==
             {1'b1, 1'b1, SZ_BYTE, 32'h200, 32'hAB, 2'b00, 2'b00}) begin
            n_err++;
            $display("FAIL st_issue k=%0d got mem=%h wd=%h gnt=%b rv=%b want mem=%h wd=ab gnt=00 rv=00",
                     k, o_mem[k], o_wd[k], o_gnt[k], o_rsp[k][65:64], {1'b1, 1'b1, SZ_BYTE, 32'h200});
         end
      end
      tick();
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if ({o_gnt[k], o_rsp[k][65:64]} !== 4'b1000) begin
            n_err++;
            $display("FAIL st_regrant k=%0d got gnt=%b rv=%b want gnt=10 rv=00",
                     k, o_gnt[k], o_rsp[k][65:64]);
         end
      end
      tick();
      ls_req = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_rr_tie();
      logic [3:0] seq [NK];
      int         cnt [NK];
      bit         done;
      logic [1:0] eg;
      logic [65:0] er;
      do_reset();
      if_req  = 1'b1;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_size = SZ_LOAD;
      done    = 1'b0;
      for (int k = 0; k < NK; k++) begin
         seq[k] = 4'h0;
         cnt[k] = 0;
      end
      for (int c = 0; c < 80 && !done; c++) begin
         if_addr = $urandom;
         ls_addr = $urandom;
         @(negedge clk);
         done = 1'b1;
         for (int k = 0; k < NK; k++) begin
            eg = m_pick(k);
            n_cmp++;
            if (o_gnt[k] !== eg) begin
               n_err++;
               $display("FAIL rr_gnt k=%0d c=%0d got %b want %b", k, c, o_gnt[k], eg);
            end
            er = m_rsp(k);
            n_cmp++;
            if (o_rsp[k] !== er) begin
               n_err++;
               $display("FAIL rr_rsp k=%0d c=%0d got %h want %h", k, c, o_rsp[k], er);
            end
            if (o_gnt[k] != 2'b00 && cnt[k] < 4) begin
               seq[k] = {seq[k][2:0], o_gnt[k][1]};
               cnt[k]++;
            end
            if (cnt[k] < 4) done = 1'b0;
         end
         tick();
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL rr_timeout got fewer than 4 grants on some instance want 4");
      end
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (seq[k] !== 4'b0101) begin
            n_err++;
            $display("FAIL rr_order k=%0d got %b want 0101 (IF,LS,IF,LS)", k, seq[k]);
         end
      end
      idle_inputs();
      repeat (8) tick();
   endtask

   task automatic test_lat4_wait();
      logic [65:0] er;
      do_reset();
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_size = SZ_LOAD;
      ls_addr = 32'h300;
      @(negedge clk);
      n_cmp++;
      if (o_gnt[2] !== 2'b10) begin
         n_err++;
         $display("FAIL l4_gnt got %b want 10", o_gnt[2]);
      end
      tick();
      ls_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_mem[2] !== {1'b1, 1'b0, SZ_LOAD, 32'h300}) begin
         n_err++;
         $display("FAIL l4_issue got %h want %h", o_mem[2], {1'b1, 1'b0, SZ_LOAD, 32'h300});
      end
      tick();
      if_req  = 1'b1;
      if_addr = 32'h44;
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         er = (c == 5) ? {2'b10, 32'h0, mem_rdata} : 66'h0;
         n_cmp++;
         if ({o_gnt[2], o_rsp[2]} !== {2'b00, er}) begin
            n_err++;
            $display("FAIL l4_wait c=%0d got gnt=%b rsp=%h want gnt=00 rsp=%h", c, o_gnt[2], o_rsp[2], er);
         end
         tick();
      end
      @(negedge clk);
      n_cmp++;
      if (o_gnt[2] !== 2'b01) begin
         n_err++;
         $display("FAIL l4_if_gnt got %b want 01", o_gnt[2]);
      end
      tick();
      if_req = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_withdraw();
      do_reset();
      ls_req  = 1'b1;
      ls_addr = 32'h500;
      tick();
      ls_req  = 1'b0;
      if_req  = 1'b1;            // raised while busy, dropped before any grant
      if_addr = 32'h600;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            n_cmp++;
            if (o_gnt[k] !== 2'b00 || (o_mem[k][35] && o_mem[k][31:0] !== 32'h500)) begin
               n_err++;
               $display("FAIL wd_no_if k=%0d c=%0d got gnt=%b mem=%h want gnt=00 and no IF issue",
                        k, c, o_gnt[k], o_mem[k]);
            end
         end
         tick();
         if_req = 1'b0;
      end
      if_req = 1'b1;
      ls_req = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_cmp++;
         if (o_gnt[k] !== 2'b01) begin
            n_err++;
            $display("FAIL wd_tie k=%0d got %b want 01", k, o_gnt[k]);
         end
      end
      tick();
      idle_inputs();
      repeat (8) tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0]  eg;
      logic [35:0] em;
      logic [65:0] er;
      logic [31:0] ewd;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         reset    = ($urandom_range(0, 63) == 0);
         if_req   = ($urandom_range(0, 3) != 0);
         ls_req   = ($urandom_range(0, 3) != 0);
         ls_we    = $urandom_range(0, 1);
         ls_size  = 2'($urandom_range(0, 3));
         if_addr  = $urandom;
         ls_addr  = $urandom;
         ls_wdata = $urandom;
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            eg  = m_pick(k);
            em  = m_mem(k);
            er  = m_rsp(k);
            ewd = (em[35] && em[34]) ? m_wd[k] : 32'h0;
            n_cmp++;
            if (o_gnt[k] !== eg) begin
               n_err++;
               $display("FAIL rnd_gnt k=%0d c=%0d got %b want %b", k, c, o_gnt[k], eg);
            end
            n_cmp++;
            if (o_mem[k] !== em) begin
               n_err++;
               $display("FAIL rnd_mem k=%0d c=%0d got %h want %h", k, c, o_mem[k], em);
            end
            if (!em[35] || em[34]) begin
               n_cmp++;
               if (o_wd[k] !== ewd) begin
                  n_err++;
                  $display("FAIL rnd_wdata k=%0d c=%0d got %h want %h", k, c, o_wd[k], ewd);
               end
            end
            n_cmp++;
            if (o_rsp[k] !== er) begin
               n_err++;
               $display("FAIL rnd_rsp k=%0d c=%0d got %h want %h", k, c, o_rsp[k], er);
            end
            n_cmp++;
            if (o_busy[k] !== (cyc < m_free[k])) begin
               n_err++;
               $display("FAIL rnd_busy k=%0d c=%0d got %b want %b", k, c, o_busy[k], cyc < m_free[k]);
            end
         end
         tick();
      end
      reset = 1'b0;
      idle_inputs();
      repeat (8) tick();
   endtask

   initial begin
      reset       = 1'b1;
      rdata_fixed = 1'b0;
      mem_rdata   = 32'h0;
      idle_inputs();
      test_reset();
      test_reset_mid_read();
      test_if_read();
      test_ls_store();
      test_rr_tie();
      test_lat4_wait();
      test_withdraw();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one data-memory port between two requesters: instruction fetch (port IF, word reads only) and the load/store unit (port LS, reads and sized stores).
- Accepts one transaction at a time with round-robin tie-break.
- Drives the single memory port for one issue cycle, waits a fixed read latency, then routes read data back to the owning requester with a valid pulse.
- Sits between the fetch/LS pipeline stages and the data RAM.

Parameters:
- RD_LAT, 1, memory read latency in cycles from the issue cycle to the cycle mem_rdata is valid; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  32  fetch word address
- if_gnt  out  1  fetch request accepted (comb, IDLE only)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetch read data; 0 when if_rvalid=0
- ls_req  in  1  load/store request
- ls_we  in  1  1=store, 0=load
- ls_size  in  2  00 load; 01 byte, 10 half, 11 word store
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data, already zero-extended
- ls_gnt  out  1  LS request accepted (comb, IDLE only)
- ls_rvalid  out  1  one-cycle pulse, ls_rdata valid (loads only)
- ls_rdata  out  32  load data, raw; 0 when ls_rvalid=0
- mem_ce  out  1  memory access enable, asserted only in ISSUE
- mem_we  out  1  1=write, only in ISSUE
- mem_size  out  2  size code forwarded to memory (fetch always 11)
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, high): state=IDLE, last_owner=LS, counter=0, captured regs=0. All outputs 0. Any outstanding read is discarded; late mem_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any req, grant one combinationally (gnt=1 that cycle), capture owner/addr/we/size/wdata, go to ISSUE. No req: stay.
  - ISSUE (exactly 1 cycle): mem_ce=1 and mem_* driven from captured regs.
    - Store: next state IDLE.
    - Read: counter<=RD_LAT-1; if RD_LAT=1 the next state is WAIT with counter already 0.
  - WAIT: decrement counter. When counter==0, assert owner's rvalid=1 with rdata=mem_rdata (comb pass-through) and go to IDLE.
- Arbitration:
  - Single requester: granted.
  - Both requesting: grant the port that was not last_owner. last_owner updates on each grant.
  - Reset tie goes to IF first. Worst-case wait is one foreign transaction.
- Timing with RD_LAT=1:
  - Read: gnt@t, ISSUE@t+1, rvalid@t+2, next gnt possible @t+3.
  - Store: gnt@t, write@t+1, next gnt @t+2.
- Outside ISSUE: mem_ce=0, mem_we=0, mem_addr/mem_size/mem_wdata=0.
- Fetch issues mem_we=0 and mem_size=11.
- LS load: mem_size=00 and mem_we=0. LS store: mem_we=1, size from ls_size.
- No sign extension here; that is done by the memory unit.
- Requester protocol:
  - Hold req and attributes stable until gnt.
  - Dropping req before gnt is a legal withdrawal.
  - Attributes are sampled only in the gnt cycle; changes after gnt have no effect.
- gnt is never asserted outside IDLE; a req raised while busy waits.
- ls_we=1 with ls_size=00 is illegal; treat it as a load (mem_we=0).
- Stores produce no rvalid.

Decomposition:
- Shared package (my_pkg):
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT}
  - typedef enum owner_t {OWN_IF, OWN_LS}
  - size constants SZ_LOAD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b11
- Sub-module rr_arbiter2: two-input round-robin grant logic with a last_owner register, clk/reset, req[1:0] in, gnt[1:0] out, and an advance strobe.

Test Plan:
1. Reset mid-read: gnt IF addr 0x100, assert reset during WAIT (RD_LAT=3) -> no if_rvalid, all outputs 0 next cycle, busy=0.
2. IF-only read, RD_LAT=1, if_addr=0x40, mem_rdata=0xDEADBEEF -> if_gnt@t, mem_ce/mem_addr=0x40/mem_size=11 @t+1, if_rvalid=1 & if_rdata=0xDEADBEEF @t+2, busy low @t+3.
3. LS byte store ls_addr=0x200, ls_wdata=0x000000AB, ls_size=01 -> mem_ce=1, mem_we=1, mem_size=01, mem_wdata=0xAB @t+1; no ls_rvalid; ls_gnt available again @t+2.
4. Simultaneous if_req & ls_req held for 4 transactions after reset -> grant order IF, LS, IF, LS; each rvalid only on owner port; other port rdata=0.
5. RD_LAT=4 LS load from 0x300 -> ls_rvalid exactly 4 cycles after the ISSUE cycle; if_req raised during WAIT gets no if_gnt until IDLE.
6. IF request withdrawn while LS busy (if_req drops before gnt) -> no IF transaction issued; last_owner unchanged.
